memory_access_sequencer: RTL and testbench

- Sequences one load or store instruction through the memory controller.
- Drives the controller's memoryMode input: LOAD for loads; STORE_PRELOAD then STORE for stores.
- Monitors the controller's error flags and tells control logic when the access is done, when rd may be written, or when a fault has occurred.
- Sits directly upstream of the memory controller, between instruction decode/control and memory.

---
 rtl/memory_access_sequencer.sv | 167 ++++++++++++++++
 tb/tb_memory_access_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: a Moore FSM that walks one load or store through the
// memory controller's mode sequence and reports completion, rd write-back or fault.
package memory_access_sequencer_pkg;

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

endpackage

module memory_access_sequencer
  import memory_access_sequencer_pkg::*;
#(
  parameter bit FAULT_STICKY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3In,
  input  logic        memoryUnalignedAccess,
  input  logic        memoryBadFunct3,
  output MemoryMode_t memoryMode,
  output logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic        rdWriteEnable,
  output logic        fault,
  output logic [1:0]  faultCause
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOAD_READ   = 3'd1,
    S_LOAD_WB     = 3'd2,
    S_STORE_PRE   = 3'd3,
    S_STORE_WRITE = 3'd4,
    S_FAULT       = 3'd5
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] funct3_q;
  logic [2:0] funct3_d;
  logic [1:0] fault_cause_q;
  logic [1:0] fault_cause_d;
  logic [1:0] err_cause_s;
  logic       err_s;

  // Bit 0 flags a misaligned address, bit 1 an unsupported access width.
  function automatic logic [1:0] encode_cause(input logic unaligned, input logic bad_funct3);
    return {bad_funct3, unaligned};
  endfunction

  assign err_cause_s = encode_cause(memoryUnalignedAccess, memoryBadFunct3);
  assign err_s       = |err_cause_s;

  // State register plus the captured funct3 and latched fault cause
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      funct3_q      <= 3'd0;
      fault_cause_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  // Next-state logic; errors are only sampled before any write is committed
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    fault_cause_d = fault_cause_q;
    case (state_q)
      S_IDLE: begin
        if (start && (opcode == OPC_LOAD)) begin
          state_d  = S_LOAD_READ;
          funct3_d = funct3In;
        end else if (start && (opcode == OPC_STORE)) begin
          state_d  = S_STORE_PRE;
          funct3_d = funct3In;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_READ: begin
        if (err_s) begin
          state_d       = S_FAULT;
          fault_cause_d = err_cause_s;
        end else begin
          state_d = S_LOAD_WB;
        end
      end
      S_LOAD_WB: begin
        state_d = S_IDLE;
      end
      S_STORE_PRE: begin
        if (err_s) begin
          state_d       = S_FAULT;
          fault_cause_d = err_cause_s;
        end else begin
          state_d = S_STORE_WRITE;
        end
      end
      S_STORE_WRITE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (FAULT_STICKY) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state only
  always_comb begin
    memoryMode    = NOP;
    busy          = 1'b1;
    done          = 1'b0;
    rdWriteEnable = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD_READ: begin
        memoryMode = LOAD;
      end
      S_LOAD_WB: begin
        memoryMode    = LOAD;
        done          = 1'b1;
        rdWriteEnable = 1'b1;
      end
      S_STORE_PRE: begin
        memoryMode = STORE_PRELOAD;
      end
      S_STORE_WRITE: begin
        memoryMode = STORE;
        done       = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign funct3     = funct3_q;
  assign faultCause = fault_cause_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Scoreboard bench for memory_access_sequencer: a sticky-fault instance is checked by
// a monitor on done/fault events, a non-sticky twin shares the stimulus.
module tb_memory_access_sequencer;
  import memory_access_sequencer_pkg::*;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3In;
  logic        ua;
  logic        bf;

  MemoryMode_t mode_s, mode_ns;
  logic [2:0]  f3_s, f3_ns;
  logic        busy_s, busy_ns, done_s, done_ns, rdwe_s, rdwe_ns, fault_s, fault_ns;
  logic [1:0]  cause_s, cause_ns;

  typedef struct packed {
    logic       done;
    logic       rdwe;
    logic       fault;
    logic [1:0] cause;
    logic [2:0] f3;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  int   store_cycles = 0;
  logic fault_prev = 1'b0;

  always #5 clock = ~clock;

  memory_access_sequencer #(.FAULT_STICKY(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .funct3In(funct3In),
    .memoryUnalignedAccess(ua), .memoryBadFunct3(bf), .memoryMode(mode_s), .funct3(f3_s),
    .busy(busy_s), .done(done_s), .rdWriteEnable(rdwe_s), .fault(fault_s), .faultCause(cause_s)
  );

  memory_access_sequencer #(.FAULT_STICKY(1'b0)) dut_ns (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .funct3In(funct3In),
    .memoryUnalignedAccess(ua), .memoryBadFunct3(bf), .memoryMode(mode_ns), .funct3(f3_ns),
    .busy(busy_ns), .done(done_ns), .rdWriteEnable(rdwe_ns), .fault(fault_ns), .faultCause(cause_ns)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic r, input logic f,
                              input logic [1:0] c, input logic [2:0] f3);
    exp_t e;
    e.done = d; e.rdwe = r; e.fault = f; e.cause = c; e.f3 = f3;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3);
    start = 1'b1; opcode = op; funct3In = f3;
    tick();
    start = 1'b0; opcode = 7'd0; funct3In = 3'd0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_pulse_mode", 32'(mode_s), 32'(NOP));
    chk("rst_pulse_busy", 32'(busy_s), 32'd0);
    chk("rst_pulse_fault", 32'(fault_s), 32'd0);
    chk("rst_pulse_cause", 32'(cause_s), 32'd0);
    chk("rst_pulse_f3", 32'(f3_s), 32'd0);
    chk("rst_pulse_ns_mode", 32'(mode_ns), 32'(NOP));
    reset = 1'b0;
    tick();
  endtask

  // Monitor: pop expected response on every done pulse or fault entry
  always @(negedge clock) begin
    exp_t e;
    if (mode_s == STORE) store_cycles++;
    if (done_s) done_count++;
    if (done_s || (fault_s && !fault_prev)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_event", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_done", 32'(done_s), 32'(e.done));
        chk("sb_rdwe", 32'(rdwe_s), 32'(e.rdwe));
        chk("sb_fault", 32'(fault_s), 32'(e.fault));
        chk("sb_cause", 32'(cause_s), 32'(e.cause));
        chk("sb_funct3", 32'(f3_s), 32'(e.f3));
      end
    end
    fault_prev = fault_s;
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 7'd0; funct3In = 3'd0; ua = 1'b0; bf = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("reset_mode", 32'(mode_s), 32'(NOP));
    chk("reset_busy", 32'(busy_s), 32'd0);
    chk("reset_done", 32'(done_s), 32'd0);
    chk("reset_rdwe", 32'(rdwe_s), 32'd0);
    chk("reset_fault", 32'(fault_s), 32'd0);
    chk("reset_f3", 32'(f3_s), 32'd0);
    chk("reset_cause", 32'(cause_s), 32'd0);
    reset = 1'b0;
    tick();

    // Plain load, funct3 010
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 3'b010));
    issue(LD, 3'b010);
    chk("ld_read_mode", 32'(mode_s), 32'(LOAD));
    chk("ld_read_busy", 32'(busy_s), 32'd1);
    chk("ld_read_done", 32'(done_s), 32'd0);
    tick();
    chk("ld_wb_mode", 32'(mode_s), 32'(LOAD));
    chk("ld_wb_done", 32'(done_s), 32'd1);
    chk("ld_wb_rdwe", 32'(rdwe_s), 32'd1);
    tick();
    chk("ld_end_mode", 32'(mode_s), 32'(NOP));
    chk("ld_end_busy", 32'(busy_s), 32'd0);

    // Plain store, funct3 000
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 3'b000));
    issue(ST, 3'b000);
    chk("st_pre_mode", 32'(mode_s), 32'(STORE_PRELOAD));
    chk("st_pre_f3", 32'(f3_s), 32'd0);
    chk("st_pre_rdwe", 32'(rdwe_s), 32'd0);
    tick();
    chk("st_wr_mode", 32'(mode_s), 32'(STORE));
    chk("st_wr_done", 32'(done_s), 32'd1);
    chk("st_wr_rdwe", 32'(rdwe_s), 32'd0);
    chk("st_wr_f3", 32'(f3_s), 32'd0);
    tick();
    chk("st_end_mode", 32'(mode_s), 32'(NOP));
    chk("st_end_busy", 32'(busy_s), 32'd0);

    // Non-memory opcode is ignored
    issue(ALU, 3'b101);
    chk("alu_mode", 32'(mode_s), 32'(NOP));
    chk("alu_busy", 32'(busy_s), 32'd0);
    chk("alu_f3", 32'(f3_s), 32'd0);
    tick();
    chk("alu_busy2", 32'(busy_s), 32'd0);

    // Load with start held while busy
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 3'b100));
    start = 1'b1; opcode = LD; funct3In = 3'b100;
    tick();
    opcode = ST; funct3In = 3'b001;
    chk("busy_ld_mode", 32'(mode_s), 32'(LOAD));
    chk("busy_ld_f3", 32'(f3_s), 32'b100);
    tick();
    chk("busy_ld_done", 32'(done_s), 32'd1);
    chk("busy_ld_wb_f3", 32'(f3_s), 32'b100);
    start = 1'b0; opcode = 7'd0; funct3In = 3'd0;
    tick();
    chk("busy_ld_idle", 32'(busy_s), 32'd0);
    chk("busy_ld_hold_f3", 32'(f3_s), 32'b100);
    tick();
    chk("busy_ld_no_restart", 32'(busy_s), 32'd0);

    // Load with bad funct3
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'b10, 3'b111));
    issue(LD, 3'b111);
    bf = 1'b1;
    chk("badf3_read_mode", 32'(mode_s), 32'(LOAD));
    tick();
    bf = 1'b0;
    chk("badf3_fault", 32'(fault_s), 32'd1);
    chk("badf3_cause", 32'(cause_s), 32'b10);
    chk("badf3_done", 32'(done_s), 32'd0);
    chk("badf3_rdwe", 32'(rdwe_s), 32'd0);
    chk("badf3_mode", 32'(mode_s), 32'(NOP));
    chk("badf3_busy", 32'(busy_s), 32'd1);
    chk("badf3_ns_fault", 32'(fault_ns), 32'd1);
    tick();
    chk("badf3_sticky", 32'(fault_s), 32'd1);
    chk("badf3_ns_cleared", 32'(fault_ns), 32'd0);
    chk("badf3_ns_cause_hold", 32'(cause_ns), 32'b10);
    pulse_reset();

    // Store with unaligned address: STORE must never appear
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 2'b01, 3'b010));
    issue(ST, 3'b010);
    ua = 1'b1;
    chk("unal_pre_mode", 32'(mode_s), 32'(STORE_PRELOAD));
    tick();
    ua = 1'b0;
    chk("unal_fault", 32'(fault_s), 32'd1);
    chk("unal_cause", 32'(cause_s), 32'b01);
    chk("unal_mode", 32'(mode_s), 32'(NOP));
    chk("unal_ns_fault", 32'(fault_ns), 32'd1);
    chk("unal_ns_cause", 32'(cause_ns), 32'b01);
    issue(ST, 3'b000);
    chk("unal_sticky_fault", 32'(fault_s), 32'd1);
    chk("unal_sticky_mode", 32'(mode_s), 32'(NOP));
    chk("unal_sticky_f3", 32'(f3_s), 32'b010);
    chk("unal_ns_idle", 32'(busy_ns), 32'd0);
    chk("unal_ns_cause_hold", 32'(cause_ns), 32'b01);
    issue(LD, 3'b000);
    chk("unal_sticky_fault2", 32'(fault_s), 32'd1);
    chk("unal_sticky_busy2", 32'(busy_s), 32'd1);
    chk("unal_sticky_cause2", 32'(cause_s), 32'b01);
    pulse_reset();

    // Asynchronous reset in the middle of STORE_PRE
    issue(ST, 3'b001);
    chk("midrst_pre_mode", 32'(mode_s), 32'(STORE_PRELOAD));
    #1 reset = 1'b1;
    #1;
    chk("midrst_mode", 32'(mode_s), 32'(NOP));
    chk("midrst_busy", 32'(busy_s), 32'd0);
    chk("midrst_f3", 32'(f3_s), 32'd0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("midrst_after_mode", 32'(mode_s), 32'(NOP));

    chk("store_cycle_count", 32'(store_cycles), 32'd1);
    chk("done_pulse_count", 32'(done_count), 32'd3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
